// File: rtl/wt_cache_pkg.sv
// Shared types and constants for the icache refill path.
// Holds the per-slot status record, the issue-state enum and the beats-per-line helper.
package wt_cache_pkg;

  localparam int unsigned CntWidth = 8;

  typedef enum logic {
    ISSUE_IDLE,
    ISSUE_PEND
  } issue_state_e;

  typedef struct packed {
    logic                busy;
    logic                nc;
    logic                err;
    logic [CntWidth-1:0] cnt;
  } slot_rec_t;

  function automatic int unsigned beats_per_line(input int unsigned line_width,
                                                 input int unsigned data_width);
    return line_width / data_width;
  endfunction

  localparam int unsigned BeatsPerLine = beats_per_line(128, 64);

endpackage

// File: rtl/icache_refill_slot.sv
// One outstanding refill: owns the line buffer, beat counter, error flag and tid.
// Busy drops on the edge that stores the last beat, so the slot is free while its line returns.
module icache_refill_slot
  import wt_cache_pkg::*;
#(
  parameter int unsigned LineWidth = 128,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned TidWidth  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alloc_i,
  input  logic [TidWidth-1:0]  alloc_tid_i,
  input  logic                 alloc_nc_i,
  input  logic                 beat_i,
  input  logic                 last_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 err_i,
  output logic                 busy_o,
  output logic [TidWidth-1:0]  tid_o,
  output logic                 err_o,
  output logic [LineWidth-1:0] line_o
);

  localparam int unsigned Beats    = beats_per_line(LineWidth, DataWidth);
  localparam int unsigned IdxWidth = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(Beats - 1);

  slot_rec_t            rec_q;
  logic [TidWidth-1:0]  tid_q;
  logic [DataWidth-1:0] words_q [Beats];
  logic [IdxWidth-1:0]  wr_idx;

  // Non-cacheable data always lands in word 0; cacheable beats follow the counter.
  assign wr_idx = rec_q.nc ? '0 : rec_q.cnt[IdxWidth-1:0];

  // NOTE: state uses non-blocking assignments so every slot samples the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rec_q <= '0;
      tid_q <= '0;
      // NOTE: the buffer is reset explicitly because the returned line must read as zero after reset.
      for (int w = 0; w < Beats; w++) words_q[w] <= '0;
    end else if (alloc_i) begin
      rec_q <= '{busy: 1'b1, nc: alloc_nc_i, err: 1'b0, cnt: '0};
      tid_q <= alloc_tid_i;
      for (int w = 0; w < Beats; w++) words_q[w] <= '0;
    end else if (beat_i && rec_q.busy) begin
      for (int w = 0; w < Beats; w++) begin
        if (IdxWidth'(w) == wr_idx) words_q[w] <= data_i;
      end
      rec_q.err <= rec_q.err | err_i;
      if (rec_q.cnt != CntMax) rec_q.cnt <= rec_q.cnt + CntWidth'(1);
      if (last_i) rec_q.busy <= 1'b0;
    end
  end

  assign busy_o = rec_q.busy;
  assign tid_o  = tid_q;
  assign err_o  = rec_q.err;

  for (genvar w = 0; w < Beats; w++) begin : g_word
    assign line_o[w*DataWidth +: DataWidth] = words_q[w];
  end

endmodule

// File: rtl/icache_axi_refill_adapter.sv
// Turns icache misses into bus read bursts and reassembles returning beats into lines.
// Up to NumTxn refills in flight; beats may interleave across slots in any order.
module icache_axi_refill_adapter
  import wt_cache_pkg::*;
#(
  parameter  int unsigned LineWidth = 128,
  parameter  int unsigned DataWidth = 64,
  parameter  int unsigned NumTxn    = 2,
  parameter  int unsigned PlenWidth = 56,
  parameter  int unsigned TidWidth  = 2,
  localparam int unsigned IdWidth   = (NumTxn > 1) ? $clog2(NumTxn) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [PlenWidth-1:0] req_paddr_i,
  input  logic                 req_nc_i,
  input  logic [TidWidth-1:0]  req_tid_i,
  output logic                 rd_req_o,
  input  logic                 rd_gnt_i,
  output logic [63:0]          rd_addr_o,
  output logic [7:0]           rd_blen_o,
  output logic [IdWidth-1:0]   rd_id_o,
  input  logic                 rd_valid_i,
  input  logic                 rd_last_i,
  input  logic [IdWidth-1:0]   rd_id_i,
  input  logic [DataWidth-1:0] rd_data_i,
  input  logic                 rd_err_i,
  output logic                 rtrn_valid_o,
  output logic [TidWidth-1:0]  rtrn_tid_o,
  output logic [LineWidth-1:0] rtrn_data_o,
  output logic                 rtrn_err_o,
  output logic                 unexp_o,
  output logic                 busy_o
);

  localparam int unsigned Beats    = beats_per_line(LineWidth, DataWidth);
  localparam logic [7:0]  BlenLine = 8'(Beats - 1);

  logic [NumTxn-1:0]    slot_busy;
  logic [NumTxn-1:0]    slot_err;
  logic [NumTxn-1:0]    alloc;
  logic [NumTxn-1:0]    beat_sel;
  logic [TidWidth-1:0]  slot_tid  [NumTxn];
  logic [LineWidth-1:0] slot_line [NumTxn];

  logic               free_any;
  logic [IdWidth-1:0] free_idx;
  logic               accept;
  logic               beat_hit;

  issue_state_e       state_q, state_d;
  logic [63:0]        addr_q;
  logic [7:0]         blen_q;
  logic [IdWidth-1:0] id_q;

  logic               ret_valid_q;
  logic [IdWidth-1:0] ret_slot_q;
  logic               unexp_q;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int s = NumTxn - 1; s >= 0; s--) begin
      if (!slot_busy[s]) begin
        free_any = 1'b1;
        free_idx = IdWidth'(s);
      end
    end
  end

  // A grant in the same cycle frees the issue register for the next request.
  assign req_ready_o = rst_ni & free_any & ((state_q == ISSUE_IDLE) | rd_gnt_i);
  assign accept      = req_valid_i & req_ready_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ISSUE_IDLE: if (accept) state_d = ISSUE_PEND;
      ISSUE_PEND: if (rd_gnt_i && !accept) state_d = ISSUE_IDLE;
      default:    state_d = ISSUE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ISSUE_IDLE;
      addr_q  <= '0;
      blen_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= 64'(req_paddr_i);
        blen_q <= req_nc_i ? 8'd0 : BlenLine;
        id_q   <= free_idx;
      end else if (state_q == ISSUE_PEND && rd_gnt_i) begin
        addr_q <= '0;
        blen_q <= '0;
        id_q   <= '0;
      end
    end
  end

  assign rd_req_o  = (state_q == ISSUE_PEND);
  assign rd_addr_o = addr_q;
  assign rd_blen_o = blen_q;
  assign rd_id_o   = id_q;

  always_comb begin
    for (int s = 0; s < NumTxn; s++) begin
      alloc[s]    = accept && (free_idx == IdWidth'(s));
      beat_sel[s] = rd_valid_i && (rd_id_i == IdWidth'(s));
    end
  end

  assign beat_hit = |(beat_sel & slot_busy);

  for (genvar s = 0; s < NumTxn; s++) begin : g_slot
    icache_refill_slot #(
      .LineWidth (LineWidth),
      .DataWidth (DataWidth),
      .TidWidth  (TidWidth)
    ) u_slot (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .alloc_i     (alloc[s]),
      .alloc_tid_i (req_tid_i),
      .alloc_nc_i  (req_nc_i),
      .beat_i      (beat_sel[s]),
      .last_i      (rd_last_i),
      .data_i      (rd_data_i),
      .err_i       (rd_err_i),
      .busy_o      (slot_busy[s]),
      .tid_o       (slot_tid[s]),
      .err_o       (slot_err[s]),
      .line_o      (slot_line[s])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ret_valid_q <= 1'b0;
      ret_slot_q  <= '0;
      unexp_q     <= 1'b0;
    end else begin
      ret_valid_q <= beat_hit & rd_last_i;
      ret_slot_q  <= rd_id_i;
      unexp_q     <= rd_valid_i & ~beat_hit;
    end
  end

  // The slot's tid and buffer stay intact until reallocation, which lands at the end of this cycle.
  always_comb begin
    rtrn_tid_o  = '0;
    rtrn_data_o = '0;
    rtrn_err_o  = 1'b0;
    if (ret_valid_q) begin
      for (int s = 0; s < NumTxn; s++) begin
        if (ret_slot_q == IdWidth'(s)) begin
          rtrn_tid_o  = slot_tid[s];
          rtrn_data_o = slot_line[s];
          rtrn_err_o  = slot_err[s];
        end
      end
    end
  end

  assign rtrn_valid_o = ret_valid_q;
  assign unexp_o      = unexp_q;
  assign busy_o       = (|slot_busy) | (state_q == ISSUE_PEND);

endmodule

// File: tb/tb_icache_axi_refill_adapter.sv
// Directed bench for the refill adapter: a table of single refills plus
// hand sequences for interleaving, full slots, unexpected beats and mid-burst reset.
module tb_icache_axi_refill_adapter;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [55:0]  req_paddr_i;
  logic         req_nc_i;
  logic [1:0]   req_tid_i;
  logic         rd_req_o;
  logic         rd_gnt_i;
  logic [63:0]  rd_addr_o;
  logic [7:0]   rd_blen_o;
  logic [0:0]   rd_id_o;
  logic         rd_valid_i;
  logic         rd_last_i;
  logic [0:0]   rd_id_i;
  logic [63:0]  rd_data_i;
  logic         rd_err_i;
  logic         rtrn_valid_o;
  logic [1:0]   rtrn_tid_o;
  logic [127:0] rtrn_data_o;
  logic         rtrn_err_o;
  logic         unexp_o;
  logic         busy_o;

  icache_axi_refill_adapter dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_paddr_i  (req_paddr_i),
    .req_nc_i     (req_nc_i),
    .req_tid_i    (req_tid_i),
    .rd_req_o     (rd_req_o),
    .rd_gnt_i     (rd_gnt_i),
    .rd_addr_o    (rd_addr_o),
    .rd_blen_o    (rd_blen_o),
    .rd_id_o      (rd_id_o),
    .rd_valid_i   (rd_valid_i),
    .rd_last_i    (rd_last_i),
    .rd_id_i      (rd_id_i),
    .rd_data_i    (rd_data_i),
    .rd_err_i     (rd_err_i),
    .rtrn_valid_o (rtrn_valid_o),
    .rtrn_tid_o   (rtrn_tid_o),
    .rtrn_data_o  (rtrn_data_o),
    .rtrn_err_o   (rtrn_err_o),
    .unexp_o      (unexp_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         nc;
    logic [1:0]   tid;
    logic [55:0]  paddr;
    int           gnt_dly;
    logic [63:0]  b0;
    logic [63:0]  b1;
    logic         e0;
    logic         e1;
    logic [7:0]   exp_blen;
    logic [127:0] exp_data;
    logic         exp_err;
  } vec_t;

  vec_t tbl [4];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid_i = 1'b0;
    req_paddr_i = '0;
    req_nc_i    = 1'b0;
    req_tid_i   = '0;
    rd_gnt_i    = 1'b0;
    rd_valid_i  = 1'b0;
    rd_last_i   = 1'b0;
    rd_id_i     = '0;
    rd_data_i   = '0;
    rd_err_i    = 1'b0;
  endtask

  task automatic beat(input logic [0:0] id, input logic [63:0] data,
                      input logic err, input logic last);
    rd_valid_i = 1'b1;
    rd_id_i    = id;
    rd_data_i  = data;
    rd_err_i   = err;
    rd_last_i  = last;
  endtask

  task automatic run_row(input int r, input vec_t v);
    int   held;
    logic stable;
    int   nbeats;
    string tag;
    tag    = $sformatf("row%0d", r);
    held   = 0;
    stable = 1'b1;
    nbeats = v.nc ? 1 : 2;
    step();
    req_valid_i = 1'b1;
    req_paddr_i = v.paddr;
    req_nc_i    = v.nc;
    req_tid_i   = v.tid;
    #1 check({tag, "_ready"}, req_ready_o, 1'b1);
    step();
    idle_inputs();
    for (int d = 0; d < v.gnt_dly; d++) begin
      if (rd_req_o === 1'b1) held++;
      if (rd_addr_o !== 64'(v.paddr) || rd_blen_o !== v.exp_blen || rd_id_o !== 1'b0)
        stable = 1'b0;
      if (d == v.gnt_dly - 1) rd_gnt_i = 1'b1;
      step();
    end
    rd_gnt_i = 1'b0;
    check({tag, "_req_held"}, 128'(held), 128'(v.gnt_dly));
    check({tag, "_req_fields"}, stable, 1'b1);
    check({tag, "_req_drop"}, rd_req_o, 1'b0);
    for (int k = 0; k < nbeats; k++) begin
      beat(1'b0, (k == 0) ? v.b0 : v.b1, (k == 0) ? v.e0 : v.e1, k == nbeats - 1);
      step();
    end
    idle_inputs();
    check({tag, "_rtrn_valid"}, rtrn_valid_o, 1'b1);
    check({tag, "_rtrn_tid"}, rtrn_tid_o, v.tid);
    check({tag, "_rtrn_data"}, rtrn_data_o, v.exp_data);
    check({tag, "_rtrn_err"}, rtrn_err_o, v.exp_err);
    step();
    check({tag, "_rtrn_pulse"}, rtrn_valid_o, 1'b0);
    check({tag, "_rtrn_zero"}, rtrn_data_o, '0);
    check({tag, "_idle"}, busy_o, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{nc: 1'b0, tid: 2'd1, paddr: 56'h1000, gnt_dly: 3,
               b0: 64'h0123_4567_89AB_CDEF, b1: 64'hFEDC_BA98_7654_3210, e0: 1'b0, e1: 1'b0,
               exp_blen: 8'd1, exp_data: 128'hFEDCBA9876543210_0123456789ABCDEF, exp_err: 1'b0};
    tbl[1] = '{nc: 1'b1, tid: 2'd2, paddr: 56'h2008, gnt_dly: 1,
               b0: 64'hDEAD, b1: 64'h0, e0: 1'b0, e1: 1'b0,
               exp_blen: 8'd0, exp_data: 128'h0000000000000000_000000000000DEAD, exp_err: 1'b0};
    tbl[2] = '{nc: 1'b0, tid: 2'd3, paddr: 56'h4000, gnt_dly: 2,
               b0: 64'h1111_1111_1111_1111, b1: 64'h2222_2222_2222_2222, e0: 1'b1, e1: 1'b0,
               exp_blen: 8'd1, exp_data: 128'h2222222222222222_1111111111111111, exp_err: 1'b1};
    tbl[3] = '{nc: 1'b0, tid: 2'd0, paddr: 56'hFF_FFFF_FFFF_FFC0, gnt_dly: 1,
               b0: 64'hAAAA_5555_AAAA_5555, b1: 64'h5555_AAAA_5555_AAAA, e0: 1'b0, e1: 1'b1,
               exp_blen: 8'd1, exp_data: 128'h5555AAAA5555AAAA_AAAA5555AAAA5555, exp_err: 1'b1};

    idle_inputs();
    rst_ni = 1'b0;
    step();
    step();
    check("rst_rd_req", rd_req_o, 1'b0);
    check("rst_ready", req_ready_o, 1'b0);
    check("rst_rtrn", rtrn_valid_o, 1'b0);
    check("rst_unexp", unexp_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    rst_ni = 1'b1;
    step();

    for (int r = 0; r < 4; r++) run_row(r, tbl[r]);

    // Two outstanding refills, third request stalls, responses interleave out of order.
    step();
    req_valid_i = 1'b1;
    req_paddr_i = 56'h3000;
    req_tid_i   = 2'd1;
    step();
    req_paddr_i = 56'h3040;
    req_tid_i   = 2'd2;
    rd_gnt_i    = 1'b1;
    #1 check("il_ready_on_gnt", req_ready_o, 1'b1);
    step();
    check("il_second_id", rd_id_o, 1'b1);
    check("il_second_addr", rd_addr_o, 64'h3040);
    req_valid_i = 1'b0;
    step();
    rd_gnt_i    = 1'b0;
    req_valid_i = 1'b1;
    req_paddr_i = 56'h3080;
    req_tid_i   = 2'd3;
    #1 check("full_ready0_a", req_ready_o, 1'b0);
    beat(1'b1, 64'hC0C0_C0C0_C0C0_C0C0, 1'b0, 1'b0);
    step();
    check("full_ready0_b", req_ready_o, 1'b0);
    beat(1'b0, 64'hD0D0_D0D0_D0D0_D0D0, 1'b0, 1'b0);
    step();
    check("full_ready0_c", req_ready_o, 1'b0);
    beat(1'b1, 64'hC1C1_C1C1_C1C1_C1C1, 1'b0, 1'b1);
    step();
    check("il_ret1_valid", rtrn_valid_o, 1'b1);
    check("il_ret1_tid", rtrn_tid_o, 2'd2);
    check("il_ret1_data", rtrn_data_o, 128'hC1C1C1C1C1C1C1C1_C0C0C0C0C0C0C0C0);
    beat(1'b0, 64'hD1D1_D1D1_D1D1_D1D1, 1'b0, 1'b1);
    #1 check("full_ready1", req_ready_o, 1'b1);
    step();
    idle_inputs();
    check("il_ret0_valid", rtrn_valid_o, 1'b1);
    check("il_ret0_tid", rtrn_tid_o, 2'd1);
    check("il_ret0_data", rtrn_data_o, 128'hD1D1D1D1D1D1D1D1_D0D0D0D0D0D0D0D0);
    check("z_req", rd_req_o, 1'b1);
    check("z_id", rd_id_o, 1'b1);
    check("z_addr", rd_addr_o, 64'h3080);
    rd_gnt_i = 1'b1;
    step();
    rd_gnt_i = 1'b0;
    check("z_no_ret", rtrn_valid_o, 1'b0);
    beat(1'b1, 64'hE0E0_E0E0_E0E0_E0E0, 1'b0, 1'b0);
    step();
    beat(1'b1, 64'hE1E1_E1E1_E1E1_E1E1, 1'b0, 1'b1);
    step();
    idle_inputs();
    check("z_ret_tid", rtrn_tid_o, 2'd3);
    check("z_ret_data", rtrn_data_o, 128'hE1E1E1E1E1E1E1E1_E0E0E0E0E0E0E0E0);
    step();
    check("z_idle", busy_o, 1'b0);

    // Beat for an idle slot: dropped, flagged, nothing returned.
    beat(1'b1, 64'h5A5A, 1'b0, 1'b1);
    step();
    idle_inputs();
    check("unexp_pulse", unexp_o, 1'b1);
    check("unexp_no_rtrn", rtrn_valid_o, 1'b0);
    step();
    check("unexp_clear", unexp_o, 1'b0);

    // Reset with one burst half-received and a second request still waiting for grant.
    req_valid_i = 1'b1;
    req_paddr_i = 56'h5000;
    req_tid_i   = 2'd1;
    step();
    req_valid_i = 1'b0;
    rd_gnt_i    = 1'b1;
    step();
    rd_gnt_i = 1'b0;
    beat(1'b0, 64'h1234, 1'b0, 1'b0);
    step();
    idle_inputs();
    req_valid_i = 1'b1;
    req_paddr_i = 56'h6000;
    req_tid_i   = 2'd2;
    step();
    idle_inputs();
    check("pre_rst_req", rd_req_o, 1'b1);
    rst_ni = 1'b0;
    step();
    check("mid_rst_req", rd_req_o, 1'b0);
    check("mid_rst_addr", rd_addr_o, '0);
    check("mid_rst_blen", rd_blen_o, '0);
    check("mid_rst_id", rd_id_o, '0);
    check("mid_rst_rtrn", rtrn_valid_o, 1'b0);
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_ready", req_ready_o, 1'b0);
    rst_ni = 1'b1;
    beat(1'b0, 64'h5678, 1'b0, 1'b1);
    step();
    idle_inputs();
    check("resid_unexp", unexp_o, 1'b1);
    check("resid_no_rtrn", rtrn_valid_o, 1'b0);
    step();
    check("resid_rtrn_after", rtrn_valid_o, 1'b0);
    check("resid_idle", busy_o, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
